// File: rtl/ysyx_23060180_lsu.sv
// ysyx_23060180_lsu: load/store unit for the MEMORY state of the multi-cycle core.
// Accepts one op from execute, runs a req/ack transaction on the data-memory port
// with byte-lane steering and load extension, then pulses a one-cycle writeback.
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   -> misaligned halfword/word ops skip the bus and complete with wb_err=1
//   undefined -> low address bits are forced to natural alignment and the op proceeds
module ysyx_23060180_lsu #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rstn_in,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_is_store,
  input  logic [2:0]  ex_func3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Last counter value before the timeout fires; the op gets exactly
  // TIMEOUT_CYCLES cycles of dmem_req before it is abandoned.
  localparam logic [CNT_W-1:0] CNT_LAST =
      (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit TIMEOUT_ON = (TIMEOUT_CYCLES != 0);

  state_t            state_reg, state_next;
  logic              is_store_reg;
  logic [2:0]        func3_reg;
  logic [31:0]       addr_reg;
  logic [31:0]       wdata_reg;
  logic [4:0]        rd_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              err_reg;
  logic [31:0]       ldata_reg;

  // ---------------------------------------------------------------
  // Decode of the incoming op (only meaningful while IDLE)
  // ---------------------------------------------------------------
  logic        legal_in;
  logic        trap_in;
  logic [1:0]  off_mask_in;
  logic [31:0] addr_in;

  // funct3 legality: loads allow 000/001/010/100/101, stores 000/001/010
  always_comb begin
    legal_in = 1'b0;
    if (ex_is_store) begin
      legal_in = (ex_func3[2] == 1'b0) && (ex_func3[1:0] != 2'b11);
    end else begin
      case (ex_func3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_in = 1'b1;
        default:                                 legal_in = 1'b0;
      endcase
    end
  end

  // Natural-alignment mask on the byte offset, by access size
  always_comb begin
    case (ex_func3[1:0])
      2'b00:   off_mask_in = 2'b11;
      2'b01:   off_mask_in = 2'b10;
      default: off_mask_in = 2'b00;
    endcase
  end

  // Aligned ops are unaffected by the mask; misaligned ops either trap before
  // reaching the bus or are silently realigned here.
  assign addr_in = {ex_addr[31:2], ex_addr[1:0] & off_mask_in};

`ifdef MISALIGN_TRAP_EN
  assign trap_in = (ex_addr[1:0] & ~off_mask_in) != 2'b00;
`else
  assign trap_in = 1'b0;
`endif

  // ---------------------------------------------------------------
  // Transaction progress signals
  // ---------------------------------------------------------------
  logic timeout_hit;
  assign timeout_hit = TIMEOUT_ON && (cnt_reg == CNT_LAST);

  // ---------------------------------------------------------------
  // Load extraction from the returned word
  // ---------------------------------------------------------------
  logic [7:0]  rbyte [4];
  logic [15:0] rhalf [2];
  logic [31:0] load_ext;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rbyte
      assign rbyte[gi] = dmem_rdata[8*gi +: 8];
    end
    for (genvar gi = 0; gi < 2; gi++) begin : g_rhalf
      assign rhalf[gi] = dmem_rdata[16*gi +: 16];
    end
  endgenerate

  // Select the addressed byte/half and sign- or zero-extend (func3[2] = unsigned)
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b = rbyte[addr_reg[1:0]];
    h = rhalf[addr_reg[1]];
    case (func3_reg[1:0])
      2'b00:   load_ext = func3_reg[2] ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   load_ext = func3_reg[2] ? {16'd0, h} : {{16{h[15]}}, h};
      default: load_ext = dmem_rdata;
    endcase
  end

  // ---------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------
  // State register with asynchronous reset back to IDLE
  always_ff @(posedge clk or negedge rstn_in) begin
    if (!rstn_in) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next-state logic; ack takes priority over a coincident timeout
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (ex_valid) begin
          state_next = (legal_in && !trap_in) ? BUSY : RESP;
        end
      end
      BUSY: begin
        if (dmem_ack || timeout_hit) begin
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers: op capture, timeout counter, load data and error flag
  always_ff @(posedge clk or negedge rstn_in) begin
    if (!rstn_in) begin
      is_store_reg <= 1'b0;
      func3_reg    <= 3'd0;
      addr_reg     <= 32'd0;
      wdata_reg    <= 32'd0;
      rd_reg       <= 5'd0;
      cnt_reg      <= '0;
      err_reg      <= 1'b0;
      ldata_reg    <= 32'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (ex_valid) begin
            is_store_reg <= ex_is_store;
            func3_reg    <= ex_func3;
            addr_reg     <= addr_in;
            wdata_reg    <= ex_wdata;
            rd_reg       <= ex_rd;
            cnt_reg      <= '0;
            err_reg      <= !(legal_in && !trap_in);
            ldata_reg    <= 32'd0;
          end
        end
        BUSY: begin
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (dmem_ack) begin
            if (!is_store_reg) begin
              ldata_reg <= load_ext;
            end
          end else if (timeout_hit) begin
            err_reg <= 1'b1;
          end
        end
        default: begin
          cnt_reg <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------
  // Store lane steering (from captured op, so it is stable across BUSY)
  // ---------------------------------------------------------------
  logic [3:0]  st_strb;
  logic [31:0] st_data;

  // Strobe and replicated write data by store size
  always_comb begin
    case (func3_reg[1:0])
      2'b00: begin
        st_strb = 4'b0001 << addr_reg[1:0];
        st_data = {4{wdata_reg[7:0]}};
      end
      2'b01: begin
        st_strb = 4'b0011 << {addr_reg[1], 1'b0};
        st_data = {2{wdata_reg[15:0]}};
      end
      default: begin
        st_strb = 4'b1111;
        st_data = wdata_reg;
      end
    endcase
  end

  // FSM: outputs, all derived from the current state so reset clears them at once
  always_comb begin
    ex_ready   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = 32'd0;
    dmem_wdata = 32'd0;
    dmem_wstrb = 4'd0;
    wb_valid   = 1'b0;
    wb_we      = 1'b0;
    wb_rd      = 5'd0;
    wb_data    = 32'd0;
    wb_err     = 1'b0;
    case (state_reg)
      IDLE: ex_ready = 1'b1;
      BUSY: begin
        dmem_req  = 1'b1;
        dmem_we   = is_store_reg;
        dmem_addr = {addr_reg[31:2], 2'b00};
        if (is_store_reg) begin
          dmem_wdata = st_data;
          dmem_wstrb = st_strb;
        end
      end
      RESP: begin
        wb_valid = 1'b1;
        wb_err   = err_reg;
        wb_rd    = rd_reg;
        wb_we    = !err_reg && !is_store_reg && (rd_reg != 5'd0);
        if (!err_reg && !is_store_reg) begin
          wb_data = ldata_reg;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060180_lsu.sv
// Testbench for ysyx_23060180_lsu: directed cases plus random ops, with a
// scoreboard for the bus side and the writeback side. Honours MISALIGN_TRAP_EN.
module tb_ysyx_23060180_lsu;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rstn_in;
  logic        ex_valid, ex_ready, ex_is_store;
  logic [2:0]  ex_func3;
  logic [31:0] ex_addr, ex_wdata;
  logic [4:0]  ex_rd;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        wb_valid, wb_we, wb_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  ysyx_23060180_lsu #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .rstn_in(rstn_in),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_is_store(ex_is_store),
    .ex_func3(ex_func3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
  } bus_t;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
  } wb_t;

  bus_t bus_q[$];
  wb_t  wb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_wb  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: derive bus and writeback expectations from the op rules
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] rd,
                       input logic [31:0] rdata, input int delay);
    int          sz;
    bit          legal, mis, err, trap;
    logic [31:0] ea, shifted, val;
    int          off, guard;
    bus_t        b;
    wb_t         w;
    sz    = int'(f3[1:0]);
    legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    mis   = (sz == 1 && addr[0]) || (sz == 2 && addr[1:0] != 2'b00);
`ifdef MISALIGN_TRAP_EN
    trap = 1'b1;
`else
    trap = 1'b0;
`endif
    err = !legal || (trap && mis);
    ea  = addr;
    if (sz == 1) ea = addr & ~32'd1;
    if (sz == 2) ea = addr & ~32'd3;
    off = int'(ea % 4);
    if (!err) begin
      b.addr  = ea & ~32'd3;
      b.we    = st;
      b.rdata = rdata;
      b.delay = delay;
      if (!st) begin
        b.wstrb = 4'd0;
        b.wdata = 32'd0;
      end else if (sz == 0) begin
        b.wstrb = 4'(1 << off);
        b.wdata = (wd & 32'hFF) * 32'h0101_0101;
      end else if (sz == 1) begin
        b.wstrb = 4'(3 << off);
        b.wdata = (wd & 32'hFFFF) * 32'h0001_0001;
      end else begin
        b.wstrb = 4'hF;
        b.wdata = wd;
      end
      bus_q.push_back(b);
      if (delay >= TO) err = 1'b1;
    end
    shifted = rdata >> (8 * off);
    if (sz == 0) begin
      val = shifted & 32'hFF;
      if (!f3[2] && val >= 32'h80) val = val + 32'hFFFF_FF00;
    end else if (sz == 1) begin
      val = shifted & 32'hFFFF;
      if (!f3[2] && val >= 32'h8000) val = val + 32'hFFFF_0000;
    end else begin
      val = rdata;
    end
    w.err  = err;
    w.rd   = rd;
    w.we   = !err && !st && rd != 5'd0;
    w.data = (!err && !st) ? val : 32'd0;
    // wait for the LSU to be ready, then present the op for one cycle
    guard = 0;
    @(negedge clk);
    while (!ex_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!ex_ready) chk("ex_ready_wait", 32'(ex_ready), 32'd1);
    wb_q.push_back(w);
    ex_valid    = 1'b1;
    ex_is_store = st;
    ex_func3    = f3;
    ex_addr     = addr;
    ex_wdata    = wd;
    ex_rd       = rd;
    @(negedge clk);
    ex_valid = 1'b0;
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while (wb_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (wb_q.size() != 0) begin
      chk("wb_timeout", 32'(wb_q.size()), 32'd0);
      wb_q.delete();
    end
  endtask

  // Bus responder/monitor: checks the request fields, acks after the chosen delay
  initial begin
    bit   active;
    int   idx;
    bus_t cur;
    active     = 1'b0;
    idx        = 0;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      dmem_ack = 1'b0;
      if (dmem_req) begin
        if (!active) begin
          active = 1'b1;
          idx    = 0;
          if (bus_q.size() == 0) begin
            chk("unexpected_req", 32'(dmem_req), 32'd0);
            cur.delay = 0;
            cur.rdata = 32'd0;
          end else begin
            cur = bus_q.pop_front();
            chk("dmem_addr", dmem_addr, cur.addr);
            chk("dmem_we", 32'(dmem_we), 32'(cur.we));
            chk("dmem_wstrb", 32'(dmem_wstrb), 32'(cur.wstrb));
            if (cur.we) chk("dmem_wdata", dmem_wdata, cur.wdata);
            $display("bus: addr=%08h we=%0b wstrb=%b wdata=%08h delay=%0d",
                     dmem_addr, dmem_we, dmem_wstrb, dmem_wdata, cur.delay);
          end
        end else begin
          idx++;
        end
        if (idx == cur.delay) begin
          dmem_ack   = 1'b1;
          dmem_rdata = cur.rdata;
        end else begin
          dmem_rdata = $urandom();
        end
      end else begin
        active = 1'b0;
      end
    end
  end

  // Writeback monitor: pops the scoreboard on every completion pulse
  initial begin
    wb_t e;
    forever begin
      @(negedge clk);
      if (wb_valid) begin
        n_wb++;
        if (wb_q.size() == 0) begin
          chk("unexpected_wb", 32'(wb_valid), 32'd0);
        end else begin
          e = wb_q.pop_front();
          chk("wb_err", 32'(wb_err), 32'(e.err));
          chk("wb_we", 32'(wb_we), 32'(e.we));
          chk("wb_rd", 32'(wb_rd), 32'(e.rd));
          chk("wb_data", wb_data, e.data);
          $display("wb: rd=%0d we=%0b err=%0b data=%08h (exp %08h)",
                   wb_rd, wb_we, wb_err, wb_data, e.data);
        end
      end
    end
  end

  // Stimulus
  initial begin
    int guard;
    int wb_before;
    rstn_in     = 1'b0;
    ex_valid    = 1'b0;
    ex_is_store = 1'b0;
    ex_func3    = 3'd0;
    ex_addr     = 32'd0;
    ex_wdata    = 32'd0;
    ex_rd       = 5'd0;
    repeat (3) @(negedge clk);
    chk("rst_ex_ready", 32'(ex_ready), 32'd1);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    rstn_in = 1'b1;

    // directed cases
    issue(1'b0, 3'b010, 32'h8000_0104, 32'd0, 5'd5, 32'hDEAD_BEEF, 3);  wait_done();
    issue(1'b0, 3'b000, 32'h8000_0003, 32'd0, 5'd6, 32'h80FF_1234, 0);  wait_done();
    issue(1'b0, 3'b100, 32'h8000_0003, 32'd0, 5'd7, 32'h80FF_1234, 1);  wait_done();
    issue(1'b1, 3'b000, 32'h8000_0002, 32'h0000_00A5, 5'd1, 32'd0, 0); wait_done();
    issue(1'b1, 3'b001, 32'h8000_0002, 32'h0000_1234, 5'd1, 32'd0, 2); wait_done();
    issue(1'b0, 3'b010, 32'h8000_0010, 32'd0, 5'd3, 32'h1111_2222, TO);      wait_done();
    issue(1'b0, 3'b010, 32'h8000_0014, 32'd0, 5'd3, 32'h3333_4444, TO - 1);  wait_done();
    issue(1'b0, 3'b010, 32'h8000_0002, 32'd0, 5'd9, 32'hCAFE_F00D, 0);       wait_done();
    issue(1'b1, 3'b011, 32'h8000_0000, 32'h1, 5'd2, 32'd0, 0);               wait_done();
    issue(1'b0, 3'b110, 32'h8000_0000, 32'd0, 5'd2, 32'd0, 0);               wait_done();

    // reset while BUSY: req must drop at once and the op must not write back
    issue(1'b0, 3'b010, 32'h8000_0020, 32'd0, 5'd4, 32'h5555_5555, 40);
    guard = 0;
    while (!dmem_req && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("busy_before_reset", 32'(dmem_req), 32'd1);
    @(negedge clk);
    wb_before = n_wb;
    #2 rstn_in = 1'b0;
    #1;
    chk("reset_req_drop", 32'(dmem_req), 32'd0);
    chk("reset_ex_ready", 32'(ex_ready), 32'd1);
    wb_q.delete();
    @(negedge clk);
    rstn_in = 1'b1;
    @(negedge clk);
    chk("post_reset_ex_ready", 32'(ex_ready), 32'd1);
    chk("no_wb_after_reset", 32'(n_wb - wb_before), 32'd0);
    issue(1'b0, 3'b010, 32'h8000_0024, 32'd0, 5'd0, 32'h7777_8888, 1); wait_done();

    // random ops
    for (int i = 0; i < 200; i++) begin
      logic [31:0] a;
      int d;
      a = 32'h8000_0000 | ($urandom() & 32'h0000_0FFF);
      d = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 1, TO + 3) : $urandom_range(0, 4);
      issue(1'($urandom()), 3'($urandom()), a, $urandom(), 5'($urandom()), $urandom(), d);
      wait_done();
    end

    repeat (3) @(negedge clk);
    chk("bus_q_empty", 32'(bus_q.size()), 32'd0);
    chk("wb_q_empty", 32'(wb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
